// File: rtl/avr_div_pkg.sv
// Shared types and helpers for the AVR iterative divider.
// Contents:
//   div_state_t     - divider FSM states (IDLE, CALC, FIX, DONE)
//   div_lat_cycles  - enabled cycles from acceptance to done for a given width
//   cnt_width       - width of the per-bit iteration counter for a given width
package avr_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // One cycle per quotient bit, plus the FIX cycle and the DONE cycle.
  function automatic int unsigned div_lat_cycles(input int unsigned width);
    return width + 2;
  endfunction

  // The counter is loaded with width-1 and counts down to 0.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/avr_div_step.sv
// Single combinational restoring-division step.
// Ports:
//   rem_in  - partial remainder (always below the divisor)
//   bit_in  - next dividend bit shifted into the remainder
//   dvs_in  - divisor magnitude
//   rem_out - updated partial remainder
//   q_bit   - quotient bit produced by this step
module avr_div_step
  import avr_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // rem_in < dvs_in, so the shifted value fits in WIDTH+1 bits and the
  // top bit of the difference is a clean borrow flag.
  always_comb begin
    rem_sh  = {rem_in, bit_in};
    diff    = rem_sh - {1'b0, dvs_in};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  end

endmodule

// File: rtl/avr_div.sv
// Iterative restoring divider for the AVR core datapath.
// One quotient bit per enabled clock; quotient, remainder and flags are
// registered in FIX and held until the next operation completes.
// Optional feature: define AVR_DIV_SIGNED_EN to enable signed division
// (sgn=1); without it sgn is ignored and all division is unsigned.
// Ports:
//   cp2     - core clock, rising edge
//   ireset  - asynchronous active-high reset
//   cp2en   - clock enable, all registers hold when low
//   start   - request, sampled only in IDLE
//   sgn     - signed division select
//   rd_in   - dividend
//   rr_in   - divisor
//   busy    - operation in progress (CALC/FIX)
//   done    - one enabled cycle pulse, results valid
//   q_out   - quotient
//   r_out   - remainder
//   dz_out  - divide-by-zero flag
//   z_out   - quotient is zero
module avr_div
  import avr_div_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int          use_rst = 1
) (
  input  logic             cp2,
  input  logic             ireset,
  input  logic             cp2en,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] rd_in,
  input  logic [WIDTH-1:0] rr_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             dz_out,
  output logic             z_out
);

  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef struct packed {
    logic [WIDTH-1:0] dvd;   // dividend shift register; collects quotient bits
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             dz;
`ifdef AVR_DIV_SIGNED_EN
    logic             neg_q;
    logic             neg_r;
`endif
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dzo;
    logic             zo;
  } dp_t;

  div_state_t       state;
  dp_t              dp_q;
  dp_t              dp_d;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

`ifdef AVR_DIV_SIGNED_EN
  logic neg_a;
  logic neg_b;
  assign neg_a = sgn & rd_in[WIDTH-1];
  assign neg_b = sgn & rr_in[WIDTH-1];
  assign mag_a = neg_a ? -rd_in : rd_in;
  assign mag_b = neg_b ? -rr_in : rr_in;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign mag_a      = rd_in;
  assign mag_b      = rr_in;
`endif

  avr_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (dp_q.rem),
    .bit_in (dp_q.dvd[WIDTH-1]),
    .dvs_in (dp_q.dvs),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  // On divide-by-zero dvd still holds the dividend magnitude, so the same
  // remainder sign fix restores the original dividend bit pattern.
  always_comb begin
    res_q = dp_q.dz ? '1 : dp_q.dvd;
    res_r = dp_q.dz ? dp_q.dvd : dp_q.rem;
`ifdef AVR_DIV_SIGNED_EN
    if (!dp_q.dz && dp_q.neg_q) res_q = -dp_q.dvd;
    if (dp_q.neg_r)             res_r = dp_q.dz ? -dp_q.dvd : -dp_q.rem;
`endif
  end

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (cp2en) begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= (rr_in == '0) ? FIX : CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          if (dp_q.cnt == '0) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    dp_d = dp_q;
    if (cp2en) begin
      case (state)
        IDLE: begin
          if (start) begin
            dp_d.dvd = mag_a;
            dp_d.dvs = mag_b;
            dp_d.rem = '0;
            dp_d.cnt = CNT_LOAD;
            dp_d.dz  = (rr_in == '0);
`ifdef AVR_DIV_SIGNED_EN
            dp_d.neg_q = neg_a ^ neg_b;
            dp_d.neg_r = neg_a;
`endif
          end
        end
        CALC: begin
          dp_d.rem = step_rem;
          dp_d.dvd = {dp_q.dvd[WIDTH-2:0], step_q};
          dp_d.cnt = dp_q.cnt - CNT_ONE;
        end
        FIX: begin
          dp_d.q   = res_q;
          dp_d.r   = res_r;
          dp_d.dzo = dp_q.dz;
          dp_d.zo  = (res_q == '0);
        end
        default: ;
      endcase
    end
  end

  // cp2en gating lives in dp_d, so both register flavours share one next-state.
  generate
    if (use_rst != 0) begin : g_rst
      always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) dp_q <= '0;
        else        dp_q <= dp_d;
      end
    end else begin : g_nrst
      always_ff @(posedge cp2) begin
        dp_q <= dp_d;
      end
    end
  endgenerate

  assign q_out  = dp_q.q;
  assign r_out  = dp_q.r;
  assign dz_out = dp_q.dzo;
  assign z_out  = dp_q.zo;

endmodule

// File: tb/tb_avr_div.sv
module tb_avr_div;
  import avr_div_pkg::*;

  localparam int unsigned W = 8;
`ifdef AVR_DIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic         cp2    = 1'b0;
  logic         ireset = 1'b1;
  logic         cp2en  = 1'b0;
  logic         start  = 1'b0;
  logic         sgn    = 1'b0;
  logic [W-1:0] rd_in  = '0;
  logic [W-1:0] rr_in  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] q_out;
  logic [W-1:0] r_out;
  logic         dz_out;
  logic         z_out;

  int total = 0;
  int bad   = 0;

  avr_div #(
    .WIDTH  (W),
    .use_rst(1)
  ) dut (
    .cp2   (cp2),
    .ireset(ireset),
    .cp2en (cp2en),
    .start (start),
    .sgn   (sgn),
    .rd_in (rd_in),
    .rr_in (rr_in),
    .busy  (busy),
    .done  (done),
    .q_out (q_out),
    .r_out (r_out),
    .dz_out(dz_out),
    .z_out (z_out)
  );

  initial forever #5 cp2 = ~cp2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division (truncating, remainder follows dividend).
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic z);
    int ia, ib, iq, ir;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; z = 1'b0;
      return;
    end
    if (s && SIGNED_BUILD) begin
      ia = $signed(a);
      ib = $signed(b);
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    iq = ia / ib;
    ir = ia % ib;
    q  = iq[W-1:0];
    r  = ir[W-1:0];
    dz = 1'b0;
    z  = (q == 0);
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int st_start, input int st_len, input bit spam,
                       input bit hold_done, input string tag);
    logic [W-1:0] exp_q, exp_r;
    logic         exp_dz, exp_z;
    int           n, lat_exp;
    bit           seen;
    ref_div(a, b, s, exp_q, exp_r, exp_dz, exp_z);
    lat_exp = ((b == 0) ? 1 : int'(div_lat_cycles(W)) - 1) + st_len;
    @(negedge cp2);
    rd_in = a; rr_in = b; sgn = s; start = 1'b1; cp2en = 1'b1;
    @(posedge cp2);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge cp2);
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_in = W'($urandom);
      rr_in = W'($urandom);
      sgn   = 1'($urandom);
      cp2en = !((n + 1) >= st_start && (n + 1) < st_start + st_len);
      @(posedge cp2);
      #1;
      n++;
      if (done) seen = 1'b1;
      else chk({tag, " busy"}, 32'(busy), 32'd1);
    end
    chk({tag, " latency"}, n, lat_exp);
    chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, " q"}, 32'(q_out), 32'(exp_q));
    chk({tag, " r"}, 32'(r_out), 32'(exp_r));
    chk({tag, " dz"}, 32'(dz_out), 32'(exp_dz));
    chk({tag, " z"}, 32'(z_out), 32'(exp_z));
    if (hold_done) begin
      repeat (2) begin
        @(negedge cp2);
        cp2en = 1'b0; start = 1'b0;
        @(posedge cp2);
        #1;
        chk({tag, " done_held"}, 32'(done), 32'd1);
      end
    end
    @(negedge cp2);
    cp2en = 1'b1; start = 1'b0;
    @(posedge cp2);
    #1;
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " q_held"}, 32'(q_out), 32'(exp_q));
  endtask

  task automatic reset_mid_op();
    int done_seen;
    done_seen = 0;
    @(negedge cp2);
    rd_in = 8'd200; rr_in = 8'd7; sgn = 1'b0; start = 1'b1; cp2en = 1'b1;
    @(posedge cp2);
    @(negedge cp2);
    start = 1'b0;
    repeat (3) @(posedge cp2);
    @(negedge cp2);
    chk("rst busy_before", 32'(busy), 32'd1);
    ireset = 1'b1;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst q", 32'(q_out), 32'd0);
    chk("rst r", 32'(r_out), 32'd0);
    chk("rst flags", {30'd0, dz_out, z_out}, 32'd0);
    repeat (2) @(posedge cp2);
    @(negedge cp2);
    ireset = 1'b0;
    repeat (12) begin
      @(posedge cp2);
      #1;
      if (done || busy) done_seen++;
    end
    chk("rst no_done", done_seen, 0);
  endtask

  initial begin
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset q", 32'(q_out), 32'd0);
    chk("reset r", 32'(r_out), 32'd0);
    chk("reset dz", 32'(dz_out), 32'd0);
    chk("reset z", 32'(z_out), 32'd0);
    repeat (2) @(negedge cp2);
    ireset = 1'b0;
    cp2en  = 1'b1;

    do_op(8'd200, 8'd7,   1'b0, 0, 0, 1'b0, 1'b0, "u200_7");
    do_op(8'd0,   8'd5,   1'b0, 0, 0, 1'b0, 1'b0, "u0_5");
    do_op(8'd13,  8'd0,   1'b0, 0, 0, 1'b0, 1'b0, "dz13");
    do_op(8'h9C,  8'h07,  1'b1, 0, 0, 1'b0, 1'b0, "s9c_7");
    do_op(8'h80,  8'hFF,  1'b1, 0, 0, 1'b0, 1'b0, "s80_ff");
    do_op(8'h85,  8'h00,  1'b1, 0, 0, 1'b0, 1'b0, "sdz85");
    do_op(8'd200, 8'd7,   1'b0, 3, 3, 1'b1, 1'b1, "stall");
    reset_mid_op();
    do_op(8'd255, 8'd16,  1'b0, 0, 0, 1'b0, 1'b0, "u255_16");

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      int st_s, st_l;
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      st_s = 0;
      st_l = 0;
      if (b != 0 && $urandom_range(0, 1) == 1) begin
        st_s = $urandom_range(1, 4);
        st_l = $urandom_range(1, 3);
      end
      do_op(a, b, 1'($urandom), st_s, st_l, 1'($urandom), 1'b0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
